// File: rtl/param_counter_pkg.sv
// Shared definitions for the param_counter block.
//   state_t : FSM state encoding (ST_RUN = 1'b0, ST_HALT = 1'b1).
//   modulus_ok : legality test for the MODULUS parameter against WIDTH.
// Optional feature macro used by the top: PARAM_COUNTER_WRAP_FLAG_EN.
package param_counter_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    // Legal when 2 <= modulus <= 2**width (evaluated at 64 bits so large widths are safe).
    function automatic bit modulus_ok(input int width, input longint modulus);
        return (modulus >= 64'sd2) && (modulus <= (64'sd1 << width));
    endfunction

endpackage

// File: rtl/param_counter_next_value.sv
// pc_next_value: combinational next-count and terminal detection.
// Ports:
//   out      in   WIDTH  current count
//   up_dn    in   1      1 = up, 0 = down
//   next_up  out  WIDTH  count after an up step (wraps MODULUS-1 -> 0)
//   next_dn  out  WIDTH  count after a down step (wraps 0 -> MODULUS-1)
//   terminal out  1      count sits at the terminal value for the given direction
// All arithmetic is WIDTH+1 bits wide so MODULUS = 2**WIDTH is represented exactly.
module pc_next_value #(
    parameter int WIDTH   = 8,
    parameter int MODULUS = 2 ** WIDTH
) (
    input  logic [WIDTH-1:0] out,
    input  logic             up_dn,
    output logic [WIDTH-1:0] next_up,
    output logic [WIDTH-1:0] next_dn,
    output logic             terminal
);

    localparam logic [WIDTH:0] MAX_VAL = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0] ONE     = (WIDTH+1)'(1);

    logic [WIDTH:0] cur;
    logic           at_max;
    logic           at_zero;

    assign cur     = {1'b0, out};
    assign at_max  = (cur == MAX_VAL);
    assign at_zero = (cur == '0);

    // The wrap cases never let the step reach MODULUS, so truncation is lossless.
    assign next_up  = at_max  ? '0 : WIDTH'(cur + ONE);
    assign next_dn  = at_zero ? WIDTH'(MAX_VAL) : WIDTH'(cur - ONE);
    assign terminal = up_dn ? at_max : at_zero;

endmodule

// File: rtl/param_counter.sv
// param_counter: modulo-MODULUS up/down counter with synchronous load and one-shot halt.
// Ports:
//   clk        in   1      clock, all state on posedge
//   reset      in   1      synchronous active-high reset
//   enable     in   1      count enable
//   up_dn      in   1      1 = up, 0 = down (not registered)
//   one_shot   in   1      1 = halt at terminal, 0 = wrap (not registered)
//   load       in   1      synchronous load strobe (beats enable, ignores state)
//   load_val   in   WIDTH  value to load, clamped to MODULUS-1
//   out        out  WIDTH  registered count
//   tc         out  1      terminal count, combinational
//   done       out  1      one-shot complete, registered
//   wrap_clr   in   1      clears the wrapped flag     (only with PARAM_COUNTER_WRAP_FLAG_EN)
//   wrapped    out  1      sticky flag set after a wrap (only with PARAM_COUNTER_WRAP_FLAG_EN)
//   fsm_state  out  1      current FSM state for observation
// Macro PARAM_COUNTER_WRAP_FLAG_EN adds the wrap_clr/wrapped pair; without it no extra logic exists.
module param_counter
    import param_counter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MODULUS = 2 ** WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_dn,
    input  logic             one_shot,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             done,
`ifdef PARAM_COUNTER_WRAP_FLAG_EN
    input  logic             wrap_clr,
    output logic             wrapped,
`endif
    output state_t           fsm_state
);

    localparam logic [WIDTH:0] MAX_VAL = (WIDTH+1)'(MODULUS - 1);

    // Elaboration-time guard on the modulus range.
    if (!modulus_ok(WIDTH, longint'(MODULUS))) begin : g_bad_modulus
        $error("param_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] out_nxt;
    logic [WIDTH-1:0] next_up;
    logic [WIDTH-1:0] next_dn;
    logic [WIDTH-1:0] load_clamped;
    logic             terminal;
    logic             counting;

    pc_next_value #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .out      (out),
        .up_dn    (up_dn),
        .next_up  (next_up),
        .next_dn  (next_dn),
        .terminal (terminal)
    );

    assign load_clamped = ({1'b0, load_val} > MAX_VAL) ? WIDTH'(MAX_VAL) : load_val;
    assign counting     = enable && (state == ST_RUN);
    assign tc           = counting && terminal;
    assign fsm_state    = state;

    // Next-state / next-count. Reset priority is applied in the register process.
    always_comb begin
        state_nxt = state;
        out_nxt   = out;
        if (load) begin
            out_nxt   = load_clamped;
            state_nxt = ST_RUN;
        end else if (counting) begin
            if (terminal && one_shot) begin
                state_nxt = ST_HALT;
            end else begin
                // At terminal the step already wraps, so one path covers both cases.
                out_nxt = up_dn ? next_up : next_dn;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RUN;
            out   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            out   <= out_nxt;
            done  <= (state_nxt == ST_HALT);
        end
    end

`ifdef PARAM_COUNTER_WRAP_FLAG_EN
    logic wrap_evt;

    assign wrap_evt = !load && counting && terminal && !one_shot;

    // Set beats clear when both occur on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrapped <= 1'b0;
        end else if (wrap_evt) begin
            wrapped <= 1'b1;
        end else if (wrap_clr) begin
            wrapped <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_param_counter.sv
module tb_param_counter;
    import param_counter_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       up_dn;
    logic       one_shot;
    logic       load;
    logic       wrap_clr;
    logic [3:0] load_val;

    logic [3:0] out_a, out_b;
    logic       tc_a, tc_b, done_a, done_b;
    state_t     st_a, st_b;
`ifdef PARAM_COUNTER_WRAP_FLAG_EN
    logic       wrapped_a, wrapped_b;
`endif

    int checks = 0;
    int errors = 0;

    // Reference state for both instances: index 0 = modulus 16, index 1 = modulus 10.
    int mods[2] = '{16, 10};
    int m_out[2];
    int m_halt[2];
    int m_wrapped[2];

    always #5 clk = ~clk;

    param_counter #(.WIDTH(4), .MODULUS(16)) u_a (
        .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .one_shot(one_shot),
        .load(load), .load_val(load_val), .out(out_a), .tc(tc_a), .done(done_a),
`ifdef PARAM_COUNTER_WRAP_FLAG_EN
        .wrap_clr(wrap_clr), .wrapped(wrapped_a),
`endif
        .fsm_state(st_a)
    );

    param_counter #(.WIDTH(4), .MODULUS(10)) u_b (
        .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .one_shot(one_shot),
        .load(load), .load_val(load_val), .out(out_b), .tc(tc_b), .done(done_b),
`ifdef PARAM_COUNTER_WRAP_FLAG_EN
        .wrap_clr(wrap_clr), .wrapped(wrapped_b),
`endif
        .fsm_state(st_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit m_term(input int i);
        return up_dn ? (m_out[i] == mods[i] - 1) : (m_out[i] == 0);
    endfunction

    // Apply one clock edge of the counter rules to the reference state.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            bit term;
            bit set_wrap;
            term     = m_term(i);
            set_wrap = 1'b0;
            if (reset) begin
                m_out[i]     = 0;
                m_halt[i]    = 0;
                m_wrapped[i] = 0;
            end else begin
                if (load) begin
                    m_out[i]  = (int'(load_val) > mods[i] - 1) ? mods[i] - 1 : int'(load_val);
                    m_halt[i] = 0;
                end else if (enable && !m_halt[i]) begin
                    if (term && one_shot) begin
                        m_halt[i] = 1;
                    end else begin
                        m_out[i] = (m_out[i] + (up_dn ? 1 : mods[i] - 1)) % mods[i];
                        set_wrap = term;
                    end
                end
                if (set_wrap) m_wrapped[i] = 1;
                else if (wrap_clr) m_wrapped[i] = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_out_a"},  32'(out_a),  32'(m_out[0]));
        check({tag, "_out_b"},  32'(out_b),  32'(m_out[1]));
        check({tag, "_done_a"}, 32'(done_a), 32'(m_halt[0]));
        check({tag, "_done_b"}, 32'(done_b), 32'(m_halt[1]));
        check({tag, "_st_a"},   32'(st_a),   32'(m_halt[0]));
        check({tag, "_st_b"},   32'(st_b),   32'(m_halt[1]));
        check({tag, "_tc_a"},   32'(tc_a),   32'(enable && !m_halt[0] && m_term(0)));
        check({tag, "_tc_b"},   32'(tc_b),   32'(enable && !m_halt[1] && m_term(1)));
`ifdef PARAM_COUNTER_WRAP_FLAG_EN
        check({tag, "_wrapped_a"}, 32'(wrapped_a), 32'(m_wrapped[0]));
        check({tag, "_wrapped_b"}, 32'(wrapped_b), 32'(m_wrapped[1]));
`endif
    endtask

    // Inputs are set away from the edge; the model and checks run 1 time unit after it.
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic r, input logic e, input logic u, input logic os,
                         input logic l, input logic [3:0] lv, input logic wc);
        reset = r; enable = e; up_dn = u; one_shot = os; load = l; load_val = lv; wrap_clr = wc;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_out[i] = 0; m_halt[i] = 0; m_wrapped[i] = 0;
        end
        drive(1, 0, 1, 0, 0, 4'd0, 0);

        // Reset for two cycles.
        tick("reset0");
        tick("reset1");
        check("reset_out_a_const", 32'(out_a), 32'd0);
        check("reset_done_b_const", 32'(done_b), 32'd0);

        // Free-running up count on modulus 16: out follows k mod 16.
        drive(0, 1, 1, 0, 0, 4'd0, 0);
        for (int k = 1; k <= 20; k++) begin
            tick("up16");
            check($sformatf("up16_seq_%0d", k), 32'(out_a), 32'(k % 16));
        end

        // Modulus 10, down from 3: 2,1,0,9,8.
        drive(0, 0, 0, 0, 1, 4'd3, 0);
        tick("load3");
        check("load3_out_b", 32'(out_b), 32'd3);
        drive(0, 1, 0, 0, 0, 4'd0, 0);
        begin
            int exp_dn[5] = '{2, 1, 0, 9, 8};
            for (int k = 0; k < 5; k++) begin
                tick("down10");
                check($sformatf("down10_seq_%0d", k), 32'(out_b), 32'(exp_dn[k]));
            end
        end

        // One-shot up from 7 on modulus 10: 8,9 then hold at 9 in HALT.
        drive(0, 0, 1, 1, 1, 4'd7, 0);
        tick("load7");
        drive(0, 1, 1, 1, 0, 4'd0, 0);
        for (int k = 0; k < 5; k++) tick("oneshot");
        check("oneshot_hold_b", 32'(out_b), 32'd9);
        check("oneshot_done_b", 32'(done_b), 32'd1);
        check("oneshot_tc_b", 32'(tc_b), 32'd0);

        // Load 12 while halted with enable high: clamps to 9 on modulus 10, no step.
        drive(0, 1, 1, 1, 1, 4'd12, 0);
        tick("loadhalt");
        check("loadhalt_out_b", 32'(out_b), 32'd9);
        check("loadhalt_out_a", 32'(out_a), 32'd12);
        check("loadhalt_done_b", 32'(done_b), 32'd0);
        check("loadhalt_st_b", 32'(st_b), 32'(ST_RUN));

        // Reset wins over load and enable.
        drive(0, 0, 1, 0, 1, 4'd5, 0);
        tick("load5");
        drive(1, 1, 1, 0, 1, 4'd7, 0);
        tick("resetprio");
        check("resetprio_out_a", 32'(out_a), 32'd0);
        check("resetprio_out_b", 32'(out_b), 32'd0);

`ifdef PARAM_COUNTER_WRAP_FLAG_EN
        // Wrap flag: set by 15->0, cleared by wrap_clr alone, set wins over clear.
        drive(0, 0, 1, 0, 1, 4'd14, 0);
        tick("wf_load");
        drive(0, 1, 1, 0, 0, 4'd0, 0);
        tick("wf_step");
        tick("wf_wrap");
        check("wf_set_a", 32'(wrapped_a), 32'd1);
        drive(0, 0, 1, 0, 0, 4'd0, 1);
        tick("wf_clr");
        check("wf_clr_a", 32'(wrapped_a), 32'd0);
        drive(0, 0, 1, 0, 1, 4'd15, 0);
        tick("wf_load15");
        drive(0, 1, 1, 0, 0, 4'd0, 1);
        tick("wf_both");
        check("wf_both_a", 32'(wrapped_a), 32'd1);
`endif

        // Randomised phase checked against the reference model.
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                  1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
                  4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
